// File: rtl/register_file.sv
// 32-entry register file with hardwired-zero x0, two combinational read ports, one write port
// and a sequential clear engine that restores every register's reset value one per cycle.
// x2/x3 reset and clear to the stack/global pointer initial values.
// Optional feature: define REGFILE_WRITE_BYPASS_EN to forward same-cycle write data to reads.
module register_file #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] SP_INIT    = 32'h7FFF_EFFC,
  parameter logic [DATA_WIDTH-1:0] GP_INIT    = 32'h1000_8000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Reg_Write_i,
  input  logic [4:0]            Write_Register_i,
  input  logic [DATA_WIDTH-1:0] Write_Data_i,
  input  logic [4:0]            Read_Register_1_i,
  input  logic [4:0]            Read_Register_2_i,
  input  logic                  Clear_i,
  output logic [DATA_WIDTH-1:0] Read_Data_1_o,
  output logic [DATA_WIDTH-1:0] Read_Data_2_o,
  output logic                  Busy_o
);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e                r_state;
  state_e                w_state_d;
  logic [4:0]            r_idx;
  logic [4:0]            w_idx_d;
  logic [DATA_WIDTH-1:0] r_regs [1:31];

  logic                  w_wr_en;
  logic [4:0]            w_wr_addr;
  logic [DATA_WIDTH-1:0] w_wr_data;

  function automatic logic [DATA_WIDTH-1:0] rst_val(input logic [4:0] idx);
    unique case (idx)
      5'd2:    rst_val = SP_INIT;
      5'd3:    rst_val = GP_INIT;
      default: rst_val = '0;
    endcase
  endfunction

  // FSM state and clear-index register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
      r_idx   <= 5'd0;
    end else begin
      r_state <= w_state_d;
      r_idx   <= w_idx_d;
    end
  end

  // Next state and the single write-port mux shared by user writes and the clear engine.
  always_comb begin
    w_state_d = r_state;
    w_idx_d   = r_idx;
    w_wr_en   = 1'b0;
    w_wr_addr = Write_Register_i;
    w_wr_data = Write_Data_i;
    unique case (r_state)
      StIdle: begin
        // A write in the same cycle as Clear_i still lands before clearing starts.
        w_wr_en = Reg_Write_i && (Write_Register_i != 5'd0);
        if (Clear_i) begin
          w_state_d = StClear;
          w_idx_d   = 5'd1;
        end
      end
      StClear: begin
        w_wr_en   = 1'b1;
        w_wr_addr = r_idx;
        w_wr_data = rst_val(r_idx);
        w_idx_d   = r_idx + 5'd1;
        // Stop on x31 so the index never wraps onto x0.
        if (r_idx == 5'd31) begin
          w_state_d = StIdle;
          w_idx_d   = 5'd0;
        end
      end
    endcase
  end

  // Register storage x1..x31; x0 is not stored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i < 32; i++) begin
        r_regs[i] <= rst_val(5'(i));
      end
    end else if (w_wr_en) begin
      r_regs[w_wr_addr] <= w_wr_data;
    end
  end

  assign Busy_o = (r_state == StClear);

  // Combinational read ports.
  always_comb begin
    Read_Data_1_o = (Read_Register_1_i == 5'd0) ? '0 : r_regs[Read_Register_1_i];
    Read_Data_2_o = (Read_Register_2_i == 5'd0) ? '0 : r_regs[Read_Register_2_i];
`ifdef REGFILE_WRITE_BYPASS_EN
    if (Reg_Write_i && !Busy_o && (Write_Register_i != 5'd0)) begin
      if (Write_Register_i == Read_Register_1_i) Read_Data_1_o = Write_Data_i;
      if (Write_Register_i == Read_Register_2_i) Read_Data_2_o = Write_Data_i;
    end
`endif
  end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios plus random traffic, all checked
// against an array-based reference model with a countdown for the clear sequence.
module tb_register_file;

  localparam logic [31:0] SpInit = 32'h7FFF_EFFC;
  localparam logic [31:0] GpInit = 32'h1000_8000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        Reg_Write_i = 1'b0;
  logic [4:0]  Write_Register_i = '0;
  logic [31:0] Write_Data_i = '0;
  logic [4:0]  Read_Register_1_i = '0;
  logic [4:0]  Read_Register_2_i = '0;
  logic        Clear_i = 1'b0;
  logic [31:0] Read_Data_1_o;
  logic [31:0] Read_Data_2_o;
  logic        Busy_o;

  register_file dut (
    .clk               (clk),
    .reset             (reset),
    .Reg_Write_i       (Reg_Write_i),
    .Write_Register_i  (Write_Register_i),
    .Write_Data_i      (Write_Data_i),
    .Read_Register_1_i (Read_Register_1_i),
    .Read_Register_2_i (Read_Register_2_i),
    .Clear_i           (Clear_i),
    .Read_Data_1_o     (Read_Data_1_o),
    .Read_Data_2_o     (Read_Data_2_o),
    .Busy_o            (Busy_o)
  );

  always #5 clk = ~clk;

  // Reference model: register contents, remaining clear cycles, next register to clear.
  logic [31:0] mdl [32];
  int          busy_left;
  int          clr_ptr;
  int          n_total = 0;
  int          n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_val(input int i);
    if (i == 2) return SpInit;
    if (i == 3) return GpInit;
    return 32'h0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mdl[i] = init_val(i);
    busy_left = 0;
    clr_ptr   = 0;
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] ra);
    logic [31:0] v;
    v = mdl[ra];
`ifdef REGFILE_WRITE_BYPASS_EN
    if (Reg_Write_i && busy_left == 0 && Write_Register_i != 5'd0 && Write_Register_i == ra)
      v = Write_Data_i;
`endif
    return v;
  endfunction

  task automatic set_in(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic clr);
    Reg_Write_i      = we;
    Write_Register_i = wa;
    Write_Data_i     = wd;
    Clear_i          = clr;
  endtask

  task automatic set_rd(input logic [4:0] r1, input logic [4:0] r2);
    Read_Register_1_i = r1;
    Read_Register_2_i = r2;
  endtask

  // Advance one clock and apply the same edge to the model (inputs are pre-edge values).
  task automatic tick();
    @(posedge clk);
    if (busy_left > 0) begin
      mdl[clr_ptr] = init_val(clr_ptr);
      clr_ptr++;
      busy_left--;
    end else begin
      if (Reg_Write_i && Write_Register_i != 5'd0) mdl[Write_Register_i] = Write_Data_i;
      if (Clear_i) begin
        busy_left = 31;
        clr_ptr   = 1;
      end
    end
    #1;
  endtask

  task automatic check_ports(input string tag);
    check_eq($sformatf("%s_rd1", tag), Read_Data_1_o, exp_read(Read_Register_1_i));
    check_eq($sformatf("%s_rd2", tag), Read_Data_2_o, exp_read(Read_Register_2_i));
    check_eq($sformatf("%s_busy", tag), {31'b0, Busy_o}, (busy_left > 0) ? 32'd1 : 32'd0);
  endtask

  // Read every register on both ports; only used while nothing can change state.
  task automatic sweep(input string tag);
    for (int i = 0; i < 32; i++) begin
      set_rd(5'(i), 5'(31 - i));
      #1;
      check_ports($sformatf("%s%0d", tag, i));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int nbusy;
    model_reset();
    #12;
    @(negedge clk);
    reset = 1'b1;
    #1;

    // Reset values.
    set_rd(5'd0, 5'd2);
    #1;
    check_eq("rst_x0", Read_Data_1_o, 32'h0);
    check_eq("rst_x2", Read_Data_2_o, 32'h7FFF_EFFC);
    set_rd(5'd3, 5'd5);
    #1;
    check_eq("rst_x3", Read_Data_1_o, 32'h1000_8000);
    check_eq("rst_x5", Read_Data_2_o, 32'h0);
    check_eq("rst_busy", {31'b0, Busy_o}, 32'd0);

    // Basic write, and x0 write discarded.
    set_in(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0);
    tick();
    set_in(1'b0, 5'd0, 32'h0, 1'b0);
    set_rd(5'd5, 5'd5);
    #1;
    check_eq("x5_p1", Read_Data_1_o, 32'hDEAD_BEEF);
    check_eq("x5_p2", Read_Data_2_o, 32'hDEAD_BEEF);
    set_in(1'b1, 5'd0, 32'h1234, 1'b0);
    tick();
    set_in(1'b0, 5'd0, 32'h0, 1'b0);
    set_rd(5'd0, 5'd0);
    #1;
    check_eq("x0_p1", Read_Data_1_o, 32'h0);
    check_eq("x0_p2", Read_Data_2_o, 32'h0);

    // Load index values, then clear with a same-cycle write to x1.
    for (int i = 1; i < 32; i++) begin
      set_in(1'b1, 5'(i), 32'(i), 1'b0);
      tick();
    end
    set_in(1'b0, 5'd0, 32'h0, 1'b0);
    sweep("load");
    set_in(1'b1, 5'd1, 32'h55, 1'b1);
    tick();
    nbusy = 0;
    for (int c = 0; c < 40; c++) begin
      set_in(1'b1, 5'd7, 32'hFF, (c % 5) == 2);
      set_rd((c == 0) ? 5'd1 : 5'($urandom_range(0, 31)), 5'd7);
      #1;
      check_ports($sformatf("clr%0d", c));
      if (!Busy_o) begin
        set_in(1'b0, 5'd0, 32'h0, 1'b0);
        break;
      end
      nbusy++;
      tick();
    end
    check_eq("clr_len", 32'(nbusy), 32'd31);
    sweep("post_clr");

    // Reset in the middle of a clear.
    set_in(1'b1, 5'd5, 32'h0000_0ABC, 1'b0);
    tick();
    set_in(1'b0, 5'd0, 32'h0, 1'b1);
    tick();
    set_in(1'b0, 5'd0, 32'h0, 1'b0);
    repeat (10) tick();
    #3;
    reset = 1'b0;
    model_reset();
    #1;
    check_eq("abort_busy", {31'b0, Busy_o}, 32'd0);
    sweep("abort");
    @(negedge clk);
    reset = 1'b1;
    #1;
    tick();
    check_ports("abort_idle");

    // Same-cycle write/read of x9.
    set_in(1'b1, 5'd9, 32'hA5A5_A5A5, 1'b0);
    set_rd(5'd9, 5'd9);
    #1;
`ifdef REGFILE_WRITE_BYPASS_EN
    check_eq("byp_x9", Read_Data_1_o, 32'hA5A5_A5A5);
`else
    check_eq("byp_x9", Read_Data_1_o, 32'h0);
`endif
    tick();
    set_in(1'b0, 5'd0, 32'h0, 1'b0);
    #1;
    check_eq("x9_after", Read_Data_2_o, 32'hA5A5_A5A5);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      set_in(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
             $urandom_range(0, 49) == 0);
      set_rd(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      #1;
      check_ports($sformatf("rnd%0d", n));
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter: DATA_WIDTH, 32, width of every register and data port.
REQ-002 Parameter: SP_INIT, 32'h7FFF_EFFC, reset/clear value of x2 (stack pointer).
REQ-003 Parameter: GP_INIT, 32'h1000_8000, reset/clear value of x3 (global pointer).
REQ-004 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-low reset.
REQ-006 Port: Reg_Write_i  input  1  write enable for the write port.
REQ-007 Port: Write_Register_i  input  5  destination register index.
REQ-008 Port: Write_Data_i  input  DATA_WIDTH  data to write.
REQ-009 Port: Read_Register_1_i  input  5  index for read port 1 (feeds ALU operand A).
REQ-010 Port: Read_Register_2_i  input  5  index for read port 2 (feeds ALU operand B path).
REQ-011 Port: Clear_i  input  1  single-cycle request to start a sequential clear.
REQ-012 Port: Read_Data_1_o  output  DATA_WIDTH  contents of register selected by port 1.
REQ-013 Port: Read_Data_2_o  output  DATA_WIDTH  contents of register selected by port 2.
REQ-014 Port: Busy_o  output  1  high while a clear sequence is in progress.

Function
REQ-015 The block SHALL hold 31 writable DATA_WIDTH registers x1..x31; x0 SHALL read as 0 always and writes to x0 SHALL be discarded.
REQ-016 Reads SHALL be combinational from the index inputs; zero-cycle read latency.
REQ-017 A write with Reg_Write_i=1, Busy_o=0 SHALL update the indexed register on the rising clk edge; visible on reads the following cycle.
REQ-018 FSM states: IDLE, CLEAR; reset state IDLE.
REQ-019 IDLE -> CLEAR when Clear_i=1 at a rising edge; a 5-bit index counter SHALL load 1 on that edge.
REQ-020 In CLEAR, each rising edge SHALL write the reset value of register[index] (0, SP_INIT for x2, GP_INIT for x3) and increment the index.
REQ-021 CLEAR -> IDLE on the edge that clears x31; sequence SHALL take exactly 31 cycles; counter SHALL not wrap into x0.
REQ-022 Busy_o SHALL be 1 exactly in state CLEAR, 0 in IDLE.
REQ-023 While Busy_o=1, Reg_Write_i SHALL be ignored and Clear_i SHALL be ignored; reads SHALL remain valid (already-cleared registers show reset values, others old values).
REQ-024 Clear_i and Reg_Write_i asserted in the same IDLE cycle: the write SHALL take effect on that edge, then clearing starts (x1 cleared on the next edge).
REQ-025 Both read ports addressing the same register SHALL return identical data.

Reset
REQ-026 On reset=0, asynchronously: all registers 0 except x2=SP_INIT, x3=GP_INIT; FSM=IDLE; counter=0; Busy_o=0.
REQ-027 Reset asserted mid-clear SHALL abort the sequence and apply REQ-026; no partial-clear state survives.
REQ-028 After reset release, Read_Data_x_o SHALL reflect reset values; first write accepted on the first rising edge with reset=1.

Configuration
REQ-029 Macro REGFILE_WRITE_BYPASS_EN: when defined, a read index equal to Write_Register_i (non-zero) with Reg_Write_i=1 and Busy_o=0 SHALL return Write_Data_i combinationally in the same cycle.
REQ-030 Without REGFILE_WRITE_BYPASS_EN, reads SHALL return stored contents only (REQ-017 timing); no bypass logic SHALL be present.

Verification
REQ-031 Reset then read x0,x2,x3,x5 -> 0, 32'h7FFF_EFFC, 32'h1000_8000, 0; Busy_o=0.
REQ-032 Write x5=32'hDEAD_BEEF, next cycle read port1=x5, port2=x5 -> both 32'hDEAD_BEEF; write x0=32'h1234 -> x0 reads 0.
REQ-033 Load x1..x31 with index values, pulse Clear_i -> Busy_o high 31 cycles; during clear a write x7=32'hFF ignored; afterwards x2/x3 = init values, all others 0.
REQ-034 Pulse Clear_i, drop reset after 10 cycles -> Busy_o=0 immediately, all registers at reset values, FSM IDLE.
REQ-035 Same-cycle write x9=32'hA5A5_A5A5 and read x9 -> 32'hA5A5_A5A5 with REGFILE_WRITE_BYPASS_EN, old value (0) without it.
